seven_segment_scan_ctrl: RTL and testbench
==========================================

# seven_segment_scan_ctrl

Scheduler that shares one registered `Binary_To_Seven_Segment` decoder between two display digits. A programmable refresh tick, or a forced update, snapshots both 4-bit digit values. The block feeds them to the decoder one after the other, honouring its pipeline latency, and captures each decoded pattern into a per-digit segment register. It sits between the counter logic and the top-level output inverters, and replaces one decoder instance per digit.

## Interface
- `REFRESH_CYCLES`, 25000: clock cycles between automatic scans; legal range ≥ 2*DEC_LATENCY+4, ≤ 2^20.
- `DEC_LATENCY`, 1: decoder input-to-output latency in clocks; legal range 1..4.
- `i_Clk`  in  1  the single clock; all logic on its rising edge.
- `i_Rst_L`  in  1  reset, synchronous, active-low.
- `i_Digit1`, `i_Digit2`  in  4 each  binary values to display; 0x0–0xF passed through unchanged.
- `i_Blank_Lead`  in  1  when 1, and the Digit1 snapshot is 0, Segment1 is forced blank.
- `i_Force`  in  1  single-cycle request for an immediate scan.
- `o_Dec_Number`  out  4  drive to the shared decoder's `i_Binary_Number`.
- `i_Dec_Segment`  in  7  decoder outputs, {G,F,E,D,C,B,A}, active-high.
- `o_Segment1`, `o_Segment2`  out  7 each  latched patterns, active-high; the top level inverts them.
- `o_Busy`  out  1  high while a scan is in progress.
- `o_Update`  out  1  one-cycle pulse when both segment registers have been refreshed.

## Operation
- Refresh counter is free-running from 0 to REFRESH_CYCLES-1 and wraps. It produces a tick in the cycle where count == REFRESH_CYCLES-1. It runs in every state.
- FSM states:
  - IDLE: waiting for a start condition.
  - DIG1: decoding Digit1.
  - DIG2: decoding Digit2.
- Start condition in IDLE is tick OR i_Force OR pending.
  - On the start edge, latch snap1 = i_Digit1 and snap2 = i_Digit2, clear pending, go to DIG1.
  - The snapshots guarantee that both digits come from the same cycle.
- DIG1:
  - o_Dec_Number = snap1 for exactly DEC_LATENCY+1 cycles, tracked by a phase counter.
  - On the last cycle, o_Segment1 loads i_Dec_Segment, or 7'h00 if i_Blank_Lead=1 and snap1=0.
  - Then go to DIG2.
- DIG2:
  - Same as DIG1, using snap2 and o_Segment2. Blanking never applies to Digit2.
  - Then go to IDLE with o_Update=1 for one cycle.
- In IDLE, o_Dec_Number holds its last value.
- Busy handling:
  - A tick arriving during DIG1 or DIG2 is dropped.
  - An i_Force arriving during DIG1 or DIG2 sets pending. Multiple forces collapse into one pending.
  - Pending starts a new scan in the first IDLE cycle.
- Simultaneous events: tick and force in the same IDLE cycle start one scan only.
- Reset (i_Rst_L=0, sampled at a clock edge):
  - State IDLE; refresh counter, phase counter, snap1/snap2 and pending all 0.
  - o_Dec_Number = 0, o_Segment1 = o_Segment2 = 7'h00 (blank), o_Busy = 0, o_Update = 0.
  - A reset mid-scan aborts the scan; no partial update survives.

## Timing
- Let L = DEC_LATENCY, and let T be the start cycle (IDLE cycle in which the start condition is true).
- DIG1 occupies T+1 .. T+1+L; o_Segment1 is new from T+2+L.
- DIG2 occupies T+2+L .. T+2+2L; o_Segment2 is new from T+3+2L.
- o_Update is high in cycle T+3+2L only; the FSM is in IDLE from T+3+2L.
- o_Busy is high in T+1 .. T+2+2L (2L+2 cycles). With L=1, a scan takes 4 busy cycles.
- Back-to-back forced scans: earliest next start is T+3+2L, so the scan period is 2L+3.
- After the reset release edge, the first automatic tick occurs REFRESH_CYCLES-1 cycles later.

## Structure
- Package `seven_seg_pkg` holds:
  - state enum {IDLE, DIG1, DIG2};
  - SEG_W = 7 and DIG_W = 4;
  - SEG_BLANK = 7'h00;
  - a localparam function giving the refresh counter width from REFRESH_CYCLES.
- One natural sub-module, `seven_seg_refresh_tick`: parameterised free-running counter with a tick output and synchronous active-low reset.
- The decoder stays outside this block. The top level wires o_Dec_Number/i_Dec_Segment to a single decoder instance.

## Test plan
All cases use REFRESH_CYCLES=8, DEC_LATENCY=1, and a behavioural decoder model with 1-cycle latency.
- Reset hold, then release → all outputs 0 / 7'h00; first tick 7 cycles after release; o_Update one cycle 5 cycles after the tick; Digit1=3, Digit2=7 → o_Segment1=7'h4F, o_Segment2=7'h07.
- Snapshot coherence: i_Digit2 changes 9→2 one cycle after the start cycle → o_Segment2 shows 9 (7'h6F), not 2.
- i_Blank_Lead=1, Digit1=0, Digit2=0 → o_Segment1=7'h00, o_Segment2=7'h3F. Same inputs with i_Blank_Lead=0 → o_Segment1=7'h3F.
- i_Force pulsed 3 times during one busy scan → exactly one extra scan, starting the first IDLE cycle after o_Update; no tick-triggered scan overlaps.
- Tick and i_Force in the same IDLE cycle → one scan; o_Busy high for 4 cycles; one o_Update pulse.
- i_Rst_L low during DIG2 → next cycle both segments 7'h00 and o_Busy=0; no o_Update; the scan restarts normally on the next tick.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the two-digit seven-segment scan controller.
// The counter-width helper is usable in localparam expressions.
package seven_seg_pkg;

    localparam int SEG_W = 7;
    localparam int DIG_W = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2
    } scan_state_t;

    function automatic int refresh_cnt_w(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/seven_seg_refresh_tick.sv
// Free-running refresh counter, 0..CYCLES-1 with wrap.
// o_Tick is high in the cycle where the count sits at its terminal value.
module seven_seg_refresh_tick
    import seven_seg_pkg::*;
#(
    parameter int CYCLES = 25000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    output logic o_Tick
);

    localparam int CNT_W = refresh_cnt_w(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             tick;

    always_comb begin
        tick    = (count_q == CNT_LAST);
        count_d = tick ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Tick = tick;

endmodule

// File: rtl/seven_segment_scan_ctrl.sv
// Time-shares one registered binary-to-seven-segment decoder between two digits.
// Both digits are snapshotted at scan start, decoded in turn, and latched per digit.
//
//   state | meaning
//   IDLE  | waiting for tick, force or pending request
//   DIG1  | decoder driven with snap1, Segment1 captured on the last phase
//   DIG2  | decoder driven with snap2, Segment2 captured, o_Update follows
module seven_segment_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_CYCLES = 25000,
    parameter int DEC_LATENCY    = 1
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic [DIG_W-1:0] i_Digit1,
    input  logic [DIG_W-1:0] i_Digit2,
    input  logic             i_Blank_Lead,
    input  logic             i_Force,
    output logic [DIG_W-1:0] o_Dec_Number,
    input  logic [SEG_W-1:0] i_Dec_Segment,
    output logic [SEG_W-1:0] o_Segment1,
    output logic [SEG_W-1:0] o_Segment2,
    output logic             o_Busy,
    output logic             o_Update
);

    localparam int PH_W = 3;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DEC_LATENCY);

    logic tick;

    scan_state_t      state_q,   state_d;
    logic [PH_W-1:0]  phase_q,   phase_d;
    logic [DIG_W-1:0] snap1_q,   snap1_d;
    logic [DIG_W-1:0] snap2_q,   snap2_d;
    logic [DIG_W-1:0] dec_num_q, dec_num_d;
    logic [SEG_W-1:0] seg1_q,    seg1_d;
    logic [SEG_W-1:0] seg2_q,    seg2_d;
    logic             pending_q, pending_d;
    logic             update_q,  update_d;
    logic             last_phase;

    seven_seg_refresh_tick #(
        .CYCLES (REFRESH_CYCLES)
    ) u_refresh_tick (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .o_Tick  (tick)
    );

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        snap1_d    = snap1_q;
        snap2_d    = snap2_q;
        dec_num_d  = dec_num_q;
        seg1_d     = seg1_q;
        seg2_d     = seg2_q;
        pending_d  = pending_q;
        update_d   = 1'b0;
        last_phase = (phase_q == PH_LAST);

        case (state_q)
            IDLE: begin
                // Tick, force and pending all collapse into a single scan.
                if (tick || i_Force || pending_q) begin
                    snap1_d   = i_Digit1;
                    snap2_d   = i_Digit2;
                    dec_num_d = i_Digit1;
                    pending_d = 1'b0;
                    phase_d   = '0;
                    state_d   = DIG1;
                end
            end

            DIG1: begin
                if (i_Force) begin
                    pending_d = 1'b1;
                end
                if (last_phase) begin
                    seg1_d    = (i_Blank_Lead && (snap1_q == '0)) ? SEG_BLANK : i_Dec_Segment;
                    dec_num_d = snap2_q;
                    phase_d   = '0;
                    state_d   = DIG2;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            DIG2: begin
                if (i_Force) begin
                    pending_d = 1'b1;
                end
                if (last_phase) begin
                    seg2_d   = i_Dec_Segment;
                    phase_d  = '0;
                    update_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            snap1_q   <= '0;
            snap2_q   <= '0;
            dec_num_q <= '0;
            seg1_q    <= SEG_BLANK;
            seg2_q    <= SEG_BLANK;
            pending_q <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            snap1_q   <= snap1_d;
            snap2_q   <= snap2_d;
            dec_num_q <= dec_num_d;
            seg1_q    <= seg1_d;
            seg2_q    <= seg2_d;
            pending_q <= pending_d;
            update_q  <= update_d;
        end
    end

    assign o_Dec_Number = dec_num_q;
    assign o_Segment1   = seg1_q;
    assign o_Segment2   = seg2_q;
    assign o_Busy       = (state_q != IDLE);
    assign o_Update     = update_q;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Bench for seven_segment_scan_ctrl with REFRESH_CYCLES=8, DEC_LATENCY=1 and a
// 1-cycle registered decoder model; expected updates are queued and checked on o_Update.
module tb_seven_segment_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic [3:0] dig1 = 4'd0;
    logic [3:0] dig2 = 4'd0;
    logic       blank = 1'b0;
    logic       frc = 1'b0;
    logic [3:0] dec_num;
    logic [6:0] dec_seg = 7'h00;
    logic [6:0] seg1;
    logic [6:0] seg2;
    logic       busy;
    logic       update;

    int cyc = 0;
    int base = 0;
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [6:0] s1;
        logic [6:0] s2;
        int         at;
    } exp_t;

    exp_t sb[$];

    seven_segment_scan_ctrl #(
        .REFRESH_CYCLES (8),
        .DEC_LATENCY    (1)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_l),
        .i_Digit1      (dig1),
        .i_Digit2      (dig2),
        .i_Blank_Lead  (blank),
        .i_Force       (frc),
        .o_Dec_Number  (dec_num),
        .i_Dec_Segment (dec_seg),
        .o_Segment1    (seg1),
        .o_Segment2    (seg2),
        .o_Busy        (busy),
        .o_Update      (update)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    always @(posedge clk) dec_seg <= seg_of(dec_num);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc - base);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (update === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_update actual=update required=none (cycle %0d)", cyc - base);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("upd_cycle", cyc - base, e.at - base);
                check("upd_seg1", {25'd0, seg1}, {25'd0, e.s1});
                check("upd_seg2", {25'd0, seg2}, {25'd0, e.s2});
            end
        end
    end

    task automatic push(input logic [6:0] s1, input logic [6:0] s2, input int rel);
        exp_t e;
        e.s1 = s1;
        e.s2 = s2;
        e.at = base + rel;
        sb.push_back(e);
    endtask

    // Advance to cycle k (relative to last reset release), just after its rising edge.
    task automatic goto(input int k);
        while (cyc < base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input bit chk);
        rst_l = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (chk) begin
            check("rst_seg1",   {25'd0, seg1}, 32'h00);
            check("rst_seg2",   {25'd0, seg2}, 32'h00);
            check("rst_busy",   {31'd0, busy}, 32'd0);
            check("rst_update", {31'd0, update}, 32'd0);
            check("rst_decnum", {28'd0, dec_num}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst_l = 1'b1;
        base  = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;

        // Reset values, first automatic tick at c7, scan timing
        do_reset(1'b1);
        dig1 = 4'd3; dig2 = 4'd7; blank = 1'b0;
        push(7'h4F, 7'h07, 12);
        goto(7);  @(negedge clk); check("t1_busy_c7",  {31'd0, busy}, 32'd0);
        goto(8);  @(negedge clk); check("t1_busy_c8",  {31'd0, busy}, 32'd1);
                                  check("t1_dec_c8",   {28'd0, dec_num}, 32'd3);
        goto(9);  @(negedge clk); check("t1_seg1_c9",  {25'd0, seg1}, 32'h00);
        goto(10); @(negedge clk); check("t1_seg1_c10", {25'd0, seg1}, 32'h4F);
                                  check("t1_dec_c10",  {28'd0, dec_num}, 32'd7);
        goto(11); @(negedge clk); check("t1_busy_c11", {31'd0, busy}, 32'd1);
        goto(12); @(negedge clk); check("t1_busy_c12", {31'd0, busy}, 32'd0);
                                  check("t1_dec_hold", {28'd0, dec_num}, 32'd7);

        // Snapshot coherence: Digit2 changes right after the c15 start
        goto(13); dig1 = 4'd5; dig2 = 4'd9;
        push(7'h6D, 7'h6F, 20);
        goto(16); dig2 = 4'd2;
        goto(21);

        // Leading-zero blanking, then blanking disabled
        do_reset(1'b0);
        dig1 = 4'd0; dig2 = 4'd0; blank = 1'b1;
        push(7'h00, 7'h3F, 12);
        goto(13); blank = 1'b0;
        push(7'h3F, 7'h3F, 20);
        goto(21);

        // Three force cycles during one scan collapse into one extra scan
        do_reset(1'b0);
        dig1 = 4'd1; dig2 = 4'd2;
        push(7'h06, 7'h5B, 12);
        push(7'h06, 7'h5B, 17);
        push(7'h66, 7'h6D, 28);
        goto(8);  frc = 1'b1;
        goto(9);  frc = 1'b0;
        goto(10); frc = 1'b1;
        goto(11); frc = 1'b1;
        goto(12); frc = 1'b0;
        @(negedge clk); check("t4_busy_c12", {31'd0, busy}, 32'd0);
        goto(13); dig1 = 4'd4; dig2 = 4'd5;
        @(negedge clk); check("t4_busy_c13", {31'd0, busy}, 32'd1);
        goto(16); @(negedge clk); check("t4_busy_c16", {31'd0, busy}, 32'd1);
        goto(17); @(negedge clk); check("t4_busy_c17", {31'd0, busy}, 32'd0);
        goto(29);

        // Tick and force coincide in c7: one scan, 4 busy cycles
        do_reset(1'b0);
        dig1 = 4'd8; dig2 = 4'hA;
        push(7'h7F, 7'h77, 12);
        busy_cnt = 0;
        for (int k = 6; k <= 13; k++) begin
            goto(k);
            frc = (k == 7);
            @(negedge clk);
            busy_cnt += int'(busy);
        end
        check("t5_busy_cycles", busy_cnt, 4);

        // Reset during DIG2 aborts the scan; next tick scans normally
        do_reset(1'b0);
        dig1 = 4'd6; dig2 = 4'hE;
        goto(10); @(negedge clk); check("t6_seg1_c10", {25'd0, seg1}, 32'h7D);
        do_reset(1'b1);
        push(7'h7D, 7'h79, 12);
        goto(13);

        @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
